// File: rtl/byte_sort_engine.sv
// byte_sort_engine: framed byte sorter between a UART receive stream and its
// transmit stream. A frame is a length byte N (1..DEPTH) followed by N payload
// bytes. Each payload byte is insertion-sorted into a register buffer in the
// cycle it arrives. The sorted bytes are then streamed back in ascending order.
// An invalid length (0 or > DEPTH) is answered with the single byte 0xEE.
//
// Optional feature macro: BYTE_SORT_LEN_HEADER_EN
//   When defined, the sorted response is preceded by the length byte N.
//
// Parameters: DEPTH is the maximum payload length (2..64). CNT_W is the width
// of the length, fill-count and read-index counters.
module byte_sort_engine #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
`ifdef BYTE_SORT_LEN_HEADER_EN
        S_HDR,
`endif
        S_ERR
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [7:0]         buf_q   [DEPTH];
    logic [7:0]         ins_buf [DEPTH];
    logic               load_buf;

    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   len_d;
    logic [CNT_W-1:0]   idx_q;
    logic [CNT_W-1:0]   idx_d;
    logic [CNT_W-1:0]   idx_inc;
    logic [CNT_W-1:0]   ins_pos;
    logic               ins_found;

    logic               rx_ready_q;
    logic               rx_ready_d;
    logic               tx_valid_q;
    logic               tx_valid_d;
    logic [7:0]         tx_data_q;
    logic [7:0]         tx_data_d;
    logic [7:0]         send_next;

    logic               rx_fire;
    logic               tx_fire;
    logic               len_ok;

    assign rx_ready_o = rx_ready_q;
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;

    // rx_ready is high only in IDLE/LOAD and tx_valid only in SEND/ERR/HDR,
    // so the two handshakes can never coincide.
    assign rx_fire = rx_valid_i && rx_ready_q;
    assign tx_fire = tx_valid_q && tx_ready_i;
    assign len_ok  = (rx_data_i != 8'h00) && (rx_data_i <= 8'(DEPTH));
    assign idx_inc = idx_q + CNT_W'(1);

    // Find the insertion slot (first stored entry strictly greater than the
    // incoming byte, keeping equal bytes stable) and build the shifted buffer.
    always_comb begin
        ins_pos   = count_q;
        ins_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ins_found && (CNT_W'(i) < count_q) && (buf_q[i] > rx_data_i)) begin
                ins_pos   = CNT_W'(i);
                ins_found = 1'b1;
            end
        end

        ins_buf[0] = (ins_pos == CNT_W'(0)) ? rx_data_i : buf_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            ins_buf[i] = buf_q[i];
            if (CNT_W'(i) == ins_pos) begin
                ins_buf[i] = rx_data_i;
            end else if ((CNT_W'(i) > ins_pos) && (CNT_W'(i) <= count_q)) begin
                ins_buf[i] = buf_q[i-1];
            end
        end
    end

    // Look up the byte that follows the one currently on tx_data_o.
    always_comb begin
        send_next = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == idx_inc) begin
                send_next = buf_q[i];
            end
        end
    end

    // Next-state logic; the registered outputs are computed from the next state
    // so they change on the same edge as the state itself.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        len_d      = len_q;
        idx_d      = idx_q;
        load_buf   = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    count_d = '0;
                    idx_d   = '0;
                    if (len_ok) begin
                        len_d   = rx_data_i[CNT_W-1:0];
                        state_d = S_LOAD;
                    end else begin
                        state_d    = S_ERR;
                        tx_valid_d = 1'b1;
                        tx_data_d  = 8'hEE;
                    end
                end
            end

            S_LOAD: begin
                if (rx_fire) begin
                    load_buf = 1'b1;
                    count_d  = count_q + CNT_W'(1);
                    if (count_q + CNT_W'(1) == len_q) begin
                        idx_d      = '0;
                        tx_valid_d = 1'b1;
`ifdef BYTE_SORT_LEN_HEADER_EN
                        state_d    = S_HDR;
                        tx_data_d  = 8'(len_q);
`else
                        state_d    = S_SEND;
                        tx_data_d  = ins_buf[0];
`endif
                    end
                end
            end

`ifdef BYTE_SORT_LEN_HEADER_EN
            S_HDR: begin
                if (tx_fire) begin
                    state_d   = S_SEND;
                    idx_d     = '0;
                    tx_data_d = buf_q[0];
                end
            end
`endif

            S_SEND: begin
                if (tx_fire) begin
                    if (idx_q == len_q - CNT_W'(1)) begin
                        state_d    = S_IDLE;
                        idx_d      = '0;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                    end else begin
                        idx_d     = idx_inc;
                        tx_data_d = send_next;
                    end
                end
            end

            S_ERR: begin
                if (tx_fire) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                end
            end

            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
                tx_data_d  = 8'h00;
            end
        endcase

        rx_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    // State, counters and the registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            rx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Sort buffer: takes the shifted/inserted image on every accepted payload byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else if (load_buf) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= ins_buf[i];
            end
        end
    end

endmodule
